instr_decode_pipe: RTL and testbench

//  Registered RV32I(+M, +Zicsr) decode stage between fetch and execute.

---
 rtl/instr_decode_pipe_pkg.sv | 68 ++++++
 rtl/instr_decode_pipe_fields.sv | 112 +++++++++++
 rtl/instr_decode_pipe.sv | 82 ++++++++
 tb/tb_instr_decode_pipe.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_decode_pipe_pkg.sv
// Shared types for the decode stage: opcode classes, immediate formats,
// the decoded bundle handed to execute, and the raw RV32 opcode values.
package instr_type;

    localparam int DEC_XLEN = 32;
    typedef logic [DEC_XLEN-1:0] xlen_t;

    typedef enum logic [3:0] {
        INVALID_TYPE   = 4'd0,
        LOAD_TYPE      = 4'd1,
        STORE_TYPE     = 4'd2,
        BRANCH_TYPE    = 4'd3,
        JAL_TYPE       = 4'd4,
        JALR_TYPE      = 4'd5,
        LUI_TYPE       = 4'd6,
        AUIPC_TYPE     = 4'd7,
        IMM_ARITH_TYPE = 4'd8,
        ARITH_TYPE     = 4'd9,
        FENCE_TYPE     = 4'd10,
        SYSTEM_TYPE    = 4'd11
    } opcode_t;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_t;

    typedef enum logic [1:0] {
        EMPTY,
        FULL,
        SKID
    } occ_state_t;

    typedef struct packed {
        opcode_t    op;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses_rd;
        logic       uses_rs1;
        logic       uses_rs2;
        logic       illegal;
        xlen_t      imm;
        xlen_t      pc;
    } decoded_instr_t;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [31:0] INSTR_ECALL  = 32'h00000073;
    localparam logic [31:0] INSTR_EBREAK = 32'h00100073;

endpackage

// File: rtl/instr_decode_pipe_fields.sv
// Pure combinational RV32I(+M, +Zicsr) field decoder: raw word and PC in,
// decoded bundle out, with legality and sign-extended immediate.
module decode_fields
    import instr_type::*;
#(
    parameter int XLEN     = 32,
    parameter bit EN_M     = 1'b1,
    parameter bit EN_ZICSR = 1'b1
) (
    input  logic [31:0]    i_instr,
    input  xlen_t          i_pc,
    output decoded_instr_t o_dec
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    imm_fmt_t    w_fmt;
    logic [31:0] w_imm32;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];

    always_comb begin
        o_dec          = '0;
        w_fmt          = IMM_NONE;
        w_imm32        = 32'd0;
        o_dec.funct3   = w_funct3;
        o_dec.funct7   = w_funct7;
        o_dec.rd       = i_instr[11:7];
        o_dec.rs1      = i_instr[19:15];
        o_dec.rs2      = i_instr[24:20];
        o_dec.pc       = i_pc;
        o_dec.op       = INVALID_TYPE;
        o_dec.illegal  = 1'b1;
        // Compressed encodings (low bits != 11) fall through as invalid.
        if (i_instr[1:0] == 2'b11) begin
            o_dec.illegal = 1'b0;
            case (w_opcode)
                OPC_LOAD: begin
                    o_dec.op = LOAD_TYPE;  w_fmt = IMM_I;
                    o_dec.uses_rd = 1'b1;  o_dec.uses_rs1 = 1'b1;
                end
                OPC_STORE: begin
                    o_dec.op = STORE_TYPE; w_fmt = IMM_S;
                    o_dec.uses_rs1 = 1'b1; o_dec.uses_rs2 = 1'b1;
                end
                OPC_BRANCH: begin
                    o_dec.op = BRANCH_TYPE; w_fmt = IMM_B;
                    o_dec.uses_rs1 = 1'b1;  o_dec.uses_rs2 = 1'b1;
                end
                OPC_JAL: begin
                    o_dec.op = JAL_TYPE; w_fmt = IMM_J; o_dec.uses_rd = 1'b1;
                end
                OPC_JALR: begin
                    o_dec.op = JALR_TYPE; w_fmt = IMM_I;
                    o_dec.uses_rd = 1'b1; o_dec.uses_rs1 = 1'b1;
                end
                OPC_LUI: begin
                    o_dec.op = LUI_TYPE; w_fmt = IMM_U; o_dec.uses_rd = 1'b1;
                end
                OPC_AUIPC: begin
                    o_dec.op = AUIPC_TYPE; w_fmt = IMM_U; o_dec.uses_rd = 1'b1;
                end
                OPC_MISC_MEM: o_dec.op = FENCE_TYPE;
                OPC_OP_IMM: begin
                    o_dec.op = IMM_ARITH_TYPE; w_fmt = IMM_I;
                    o_dec.uses_rd = 1'b1; o_dec.uses_rs1 = 1'b1;
                    if (w_funct3 == 3'b001)
                        o_dec.illegal = (w_funct7 != 7'b0000000);
                    else if (w_funct3 == 3'b101)
                        o_dec.illegal = !(w_funct7 == 7'b0000000 || w_funct7 == 7'b0100000);
                end
                OPC_OP: begin
                    o_dec.op = ARITH_TYPE;
                    o_dec.uses_rd = 1'b1; o_dec.uses_rs1 = 1'b1; o_dec.uses_rs2 = 1'b1;
                    case (w_funct7)
                        7'b0000000: o_dec.illegal = 1'b0;
                        7'b0100000: o_dec.illegal = !(w_funct3 == 3'b000 || w_funct3 == 3'b101);
                        7'b0000001: o_dec.illegal = !EN_M;
                        default:    o_dec.illegal = 1'b1;
                    endcase
                end
                OPC_SYSTEM: begin
                    o_dec.op = SYSTEM_TYPE; w_fmt = IMM_I;
                    // funct3=0 is only ECALL/EBREAK; CSR ops read rs1 only in register form.
                    if (w_funct3 == 3'b000) begin
                        o_dec.illegal = !(i_instr == INSTR_ECALL || i_instr == INSTR_EBREAK);
                    end else begin
                        o_dec.illegal  = !EN_ZICSR || (w_funct3 == 3'b100);
                        o_dec.uses_rd  = 1'b1;
                        o_dec.uses_rs1 = !w_funct3[2];
                    end
                end
                default: o_dec.illegal = 1'b1;
            endcase
        end
        case (w_fmt)
            IMM_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U:   w_imm32 = {i_instr[31:12], 12'd0};
            IMM_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                i_instr[20], i_instr[30:21], 1'b0};
            default: w_imm32 = 32'd0;
        endcase
        o_dec.imm = xlen_t'(XLEN'($signed(w_imm32)));
    end

endmodule

// File: rtl/instr_decode_pipe.sv
// Registered decode stage: decodes on accept into an output register backed
// by a one-entry skid register so fetch sees no combinational back-pressure.
module instr_decode_pipe
    import instr_type::*;
#(
    parameter int XLEN     = 32,
    parameter bit EN_M     = 1'b1,
    parameter bit EN_ZICSR = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output decoded_instr_t   out_dec
);

    occ_state_t     r_state;
    decoded_instr_t r_outReg;
    decoded_instr_t r_skidReg;
    decoded_instr_t w_decIn;
    logic           w_accept;
    logic           w_drain;

    decode_fields #(
        .XLEN     (XLEN),
        .EN_M     (EN_M),
        .EN_ZICSR (EN_ZICSR)
    ) u_decodeFields (
        .i_instr (in_instr),
        .i_pc    (xlen_t'(in_pc)),
        .o_dec   (w_decIn)
    );

    assign in_ready  = (r_state != SKID) && !rst;
    assign out_valid = (r_state != EMPTY);
    assign out_dec   = r_outReg;
    assign w_accept  = in_valid && in_ready;
    assign w_drain   = out_valid && out_ready;

    // Flush wins over everything; the skid entry is always the younger word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= EMPTY;
            r_outReg  <= '0;
            r_skidReg <= '0;
        end else if (flush) begin
            r_state <= EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_outReg <= w_decIn;
                        r_state  <= FULL;
                    end
                end
                FULL: begin
                    if (w_accept && w_drain) begin
                        r_outReg <= w_decIn;
                    end else if (w_accept) begin
                        r_skidReg <= w_decIn;
                        r_state   <= SKID;
                    end else if (w_drain) begin
                        r_state <= EMPTY;
                    end
                end
                SKID: begin
                    if (w_drain) begin
                        r_outReg <= r_skidReg;
                        r_state  <= FULL;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Directed bench for instr_decode_pipe: scoreboard of expected bundles pushed
// on accept and popped on every output transfer, plus handshake/flush/reset checks.
module tb_instr_decode_pipe;
    import instr_type::*;

    typedef struct {
        decoded_instr_t dec;
        logic           illNoM;
    } exp_t;

    logic           clk;
    logic           rst;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [31:0]    in_instr;
    logic [31:0]    in_pc;
    logic           out_valid;
    logic           out_ready;
    decoded_instr_t out_dec;
    logic           in_readyNoM;
    logic           out_validNoM;
    decoded_instr_t out_decNoM;

    int   checks = 0;
    int   errors = 0;
    int   popCount = 0;
    int   stallCycles = 0;
    exp_t expQ[$];
    exp_t curExp;
    exp_t popped;

    instr_decode_pipe #(.XLEN(32), .EN_M(1'b1), .EN_ZICSR(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_dec(out_dec)
    );

    instr_decode_pipe #(.XLEN(32), .EN_M(1'b0), .EN_ZICSR(1'b1)) dutNoM (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_readyNoM), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_validNoM), .out_ready(out_ready), .out_dec(out_decNoM)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mkExp(input logic [31:0] w, input logic [31:0] pc, input opcode_t op,
                                   input logic [31:0] imm, input logic ill, input logic illNoM,
                                   input logic [2:0] uses);
        exp_t e;
        e.dec          = '0;
        e.dec.op       = op;
        e.dec.funct3   = w[14:12];
        e.dec.funct7   = w[31:25];
        e.dec.rd       = w[11:7];
        e.dec.rs1      = w[19:15];
        e.dec.rs2      = w[24:20];
        e.dec.uses_rd  = uses[2];
        e.dec.uses_rs1 = uses[1];
        e.dec.uses_rs2 = uses[0];
        e.dec.illegal  = ill;
        e.dec.imm      = imm;
        e.dec.pc       = pc;
        e.illNoM       = illNoM;
        return e;
    endfunction

    function automatic logic [31:0] addiWord(input int k);
        logic [31:0] kv;
        kv = k;
        return {kv[11:0], 5'd0, 3'b000, 5'd1, 7'b0010011};
    endfunction

    function automatic exp_t addiExp(input int k, input logic [31:0] pc);
        return mkExp(addiWord(k), pc, IMM_ARITH_TYPE, 32'(k), 1'b0, 1'b0, 3'b110);
    endfunction

    // Offer a word until it is accepted (bounded), leaving the bench just after the accepting edge.
    task automatic applyStimulus(input logic [31:0] w, input logic [31:0] pc, input exp_t e);
        bit done;
        done     = 1'b0;
        curExp   = e;
        in_instr = w;
        in_pc    = pc;
        in_valid = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            else stallCycles++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) checkOutput("acceptTimeout", 128'(done), 128'd1);
    endtask

    task automatic waitDrain();
        for (int c = 0; c < 30; c++) begin
            if (expQ.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        checkOutput("drainQueueEmpty", 128'(expQ.size()), 128'd0);
        checkOutput("drainOutIdle", 128'(out_valid), 128'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("outputWithoutExpectation", 128'(expQ.size()), 128'd1);
                end else begin
                    popped = expQ.pop_front();
                    popCount++;
                    checkOutput("outDec", 128'(out_dec), 128'(popped.dec));
                    checkOutput("illegalNoM", 128'(out_decNoM.illegal), 128'(popped.illNoM));
                end
            end
            if (in_valid && in_ready && !flush) expQ.push_back(curExp);
        end
    end

    initial begin
        int popBase;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        in_pc     = 32'd0;
        out_ready = 1'b0;
        curExp    = addiExp(0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetOutValid", 128'(out_valid), 128'd0);
        checkOutput("resetInReady", 128'(in_ready), 128'd0);
        checkOutput("resetOutDec", 128'(out_dec), 128'd0);
        rst = 1'b0;
        #1;
        checkOutput("postResetInReady", 128'(in_ready), 128'd1);
        checkOutput("postResetOutValid", 128'(out_valid), 128'd0);

        $display("[TB] directed decode stream");
        out_ready = 1'b1;
        applyStimulus(32'h00500093, 32'h1000, mkExp(32'h00500093, 32'h1000, IMM_ARITH_TYPE, 32'd5, 0, 0, 3'b110));
        checkOutput("firstLatency", 128'(out_valid), 128'd1);
        applyStimulus(32'hFE000EE3, 32'h1004, mkExp(32'hFE000EE3, 32'h1004, BRANCH_TYPE, 32'hFFFFFFFC, 0, 0, 3'b011));
        applyStimulus(32'h02208033, 32'h1008, mkExp(32'h02208033, 32'h1008, ARITH_TYPE, 32'd0, 0, 1, 3'b111));
        applyStimulus(32'h0020A423, 32'h100C, mkExp(32'h0020A423, 32'h100C, STORE_TYPE, 32'd8, 0, 0, 3'b011));
        applyStimulus(32'h123452B7, 32'h1010, mkExp(32'h123452B7, 32'h1010, LUI_TYPE, 32'h12345000, 0, 0, 3'b100));
        applyStimulus(32'hFF9FF0EF, 32'h1014, mkExp(32'hFF9FF0EF, 32'h1014, JAL_TYPE, 32'hFFFFFFF8, 0, 0, 3'b100));
        applyStimulus(32'h00000073, 32'h1018, mkExp(32'h00000073, 32'h1018, SYSTEM_TYPE, 32'd0, 0, 0, 3'b000));
        applyStimulus(32'h300022F3, 32'h101C, mkExp(32'h300022F3, 32'h101C, SYSTEM_TYPE, 32'h300, 0, 0, 3'b110));
        applyStimulus(32'h00004073, 32'h1020, mkExp(32'h00004073, 32'h1020, SYSTEM_TYPE, 32'd0, 1, 1, 3'b100));
        applyStimulus(32'h40001033, 32'h1024, mkExp(32'h40001033, 32'h1024, ARITH_TYPE, 32'd0, 1, 1, 3'b111));
        applyStimulus(32'h00000001, 32'h1028, mkExp(32'h00000001, 32'h1028, INVALID_TYPE, 32'd0, 1, 1, 3'b000));
        applyStimulus(32'h0000007F, 32'h102C, mkExp(32'h0000007F, 32'h102C, INVALID_TYPE, 32'd0, 1, 1, 3'b000));
        applyStimulus(32'h4030D093, 32'h1030, mkExp(32'h4030D093, 32'h1030, IMM_ARITH_TYPE, 32'h403, 0, 0, 3'b110));
        applyStimulus(32'h40309093, 32'h1034, mkExp(32'h40309093, 32'h1034, IMM_ARITH_TYPE, 32'h403, 1, 1, 3'b110));
        waitDrain();

        $display("[TB] back-pressure");
        out_ready = 1'b0;
        applyStimulus(addiWord(10), 32'h2000, addiExp(10, 32'h2000));
        applyStimulus(addiWord(11), 32'h2004, addiExp(11, 32'h2004));
        curExp   = addiExp(12, 32'h2008);
        in_instr = addiWord(12);
        in_pc    = 32'h2008;
        in_valid = 1'b1;
        @(negedge clk);
        checkOutput("bpInReadyLow", 128'(in_ready), 128'd0);
        checkOutput("bpHeadStalled", 128'(out_dec), 128'(addiExp(10, 32'h2000).dec));
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("bpHeadStable", 128'(out_dec), 128'(addiExp(10, 32'h2000).dec));
        checkOutput("bpInReadyStillLow", 128'(in_ready), 128'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(addiWord(12), 32'h2008, addiExp(12, 32'h2008));
        applyStimulus(addiWord(13), 32'h200C, addiExp(13, 32'h200C));
        waitDrain();

        $display("[TB] flush while skid is occupied");
        out_ready = 1'b0;
        applyStimulus(addiWord(20), 32'h3000, addiExp(20, 32'h3000));
        applyStimulus(addiWord(21), 32'h3004, addiExp(21, 32'h3004));
        curExp   = addiExp(22, 32'h3008);
        in_instr = addiWord(22);
        in_pc    = 32'h3008;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        expQ.delete();
        checkOutput("flushSkidOutValid", 128'(out_valid), 128'd0);
        checkOutput("flushSkidInReady", 128'(in_ready), 128'd1);
        out_ready = 1'b1;
        applyStimulus(addiWord(23), 32'h300C, addiExp(23, 32'h300C));
        checkOutput("postFlushLatency", 128'(out_valid), 128'd1);
        checkOutput("postFlushHead", 128'(out_dec), 128'(addiExp(23, 32'h300C).dec));
        waitDrain();

        $display("[TB] flush in FULL with output taken and input offered");
        out_ready = 1'b0;
        applyStimulus(addiWord(24), 32'h3010, addiExp(24, 32'h3010));
        out_ready = 1'b1;
        curExp    = addiExp(25, 32'h3014);
        in_instr  = addiWord(25);
        in_pc     = 32'h3014;
        in_valid  = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flushFullOutValid", 128'(out_valid), 128'd0);
        checkOutput("flushFullTaken", 128'(expQ.size()), 128'd0);

        $display("[TB] reset mid-stream");
        out_ready = 1'b0;
        applyStimulus(addiWord(30), 32'h4000, addiExp(30, 32'h4000));
        applyStimulus(addiWord(31), 32'h4004, addiExp(31, 32'h4004));
        checkOutput("skidInReadyLow", 128'(in_ready), 128'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midResetOutValid", 128'(out_valid), 128'd0);
        checkOutput("midResetInReady", 128'(in_ready), 128'd0);
        expQ.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("releaseInReady", 128'(in_ready), 128'd1);
        checkOutput("releaseOutValid", 128'(out_valid), 128'd0);

        $display("[TB] full throughput");
        out_ready   = 1'b1;
        stallCycles = 0;
        popBase     = popCount;
        for (int k = 0; k < 100; k++)
            applyStimulus(addiWord(100 + k), 32'h5000 + 32'(4 * k), addiExp(100 + k, 32'h5000 + 32'(4 * k)));
        checkOutput("throughputNoStall", 128'(stallCycles), 128'd0);
        waitDrain();
        checkOutput("throughputCount", 128'(popCount - popBase), 128'd100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
